// File: rtl/canny_seq_pkg.sv
// Shared types and constants for the Canny frame sequencer: state encoding,
// counter/dimension widths, reset dimensions and error-flag bit positions.
package canny_seq_pkg;

    localparam int CNT_W = 32;
    localparam int DIM_W = 16;
    localparam int ERR_W = 3;

    localparam logic [DIM_W-1:0] DEF_WIDTH  = 16'd640;
    localparam logic [DIM_W-1:0] DEF_HEIGHT = 16'd480;

    localparam int ERR_ZERO_DIM    = 0;
    localparam int ERR_EARLY_EOV   = 1;
    localparam int ERR_MISSING_EOV = 2;

    typedef enum logic [2:0] {
        IDLE,
        CTRL,
        STREAM,
        PAD,
        FLUSH,
        DRAIN
    } seq_state_e;

endpackage

// File: rtl/canny_seq_out_stage.sv
// Output side of the sequencer: drops pipeline warm-up pixels, registers
// the forwarded pixels with stall hold, and flags end-of-video on the last one.
module canny_seq_out_stage
    import canny_seq_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             clear,
    input  logic [CNT_W-1:0] total,
    input  logic [CNT_W-1:0] skip,
    input  logic             pipe_empty,
    input  logic [PIX_W-1:0] pipe_dout,
    output logic             pipe_rd_en,
    input  logic             out_stall,
    output logic             out_write,
    output logic [PIX_W-1:0] out_data,
    output logic             out_eov,
    output logic             done
);

    logic [CNT_W-1:0] sk_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic             skipping;
    logic             xfer;

    assign skipping   = sk_cnt < skip;
    assign xfer       = out_write & ~out_stall;
    // Warm-up pops never touch the output register, so they ignore the stall.
    assign pipe_rd_en = active & ~pipe_empty & (skipping | ~out_write | ~out_stall)
                        & (out_cnt < total);
    assign done       = (out_cnt == total) & ~(out_write & out_stall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sk_cnt    <= '0;
            out_cnt   <= '0;
            out_write <= 1'b0;
            out_data  <= '0;
            out_eov   <= 1'b0;
        end else if (clear) begin
            sk_cnt    <= '0;
            out_cnt   <= '0;
            out_write <= 1'b0;
        end else if (pipe_rd_en && skipping) begin
            sk_cnt <= sk_cnt + CNT_W'(1);
            if (xfer) out_write <= 1'b0;
        end else if (pipe_rd_en) begin
            out_data  <= pipe_dout;
            out_write <= 1'b1;
            out_eov   <= (out_cnt == total - CNT_W'(1));
            out_cnt   <= out_cnt + CNT_W'(1);
        end else if (xfer) begin
            out_write <= 1'b0;
        end
    end

endmodule

// File: rtl/canny_frame_sequencer.sv
// Frame controller around the line-buffered Canny pipeline: latches frame size,
// feeds input pixels plus zero flush pixels, and forwards exactly W*H outputs.
module canny_frame_sequencer
    import canny_seq_pkg::*;
#(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3,
    parameter int PIPE_LINES       = 4,
    parameter int PIPE_EXTRA       = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      vip_ctrl_valid,
    input  logic [DIM_W-1:0]                          width_in,
    input  logic [DIM_W-1:0]                          height_in,
    input  logic                                      ctrl_busy,
    output logic                                      ctrl_send,
    output logic [DIM_W-1:0]                          width_out,
    output logic [DIM_W-1:0]                          height_out,
    input  logic                                      src_valid,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] src_data,
    input  logic                                      src_eov,
    output logic                                      src_read,
    output logic                                      pipe_wr_en,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] pipe_din,
    input  logic                                      pipe_full,
    input  logic                                      pipe_empty,
    output logic                                      pipe_rd_en,
    input  logic [BITS_PER_SYMBOL-1:0]                pipe_dout,
    output logic                                      out_write,
    output logic [BITS_PER_SYMBOL-1:0]                out_data,
    output logic                                      out_eov,
    input  logic                                      out_stall,
    output logic                                      busy,
    output logic [ERR_W-1:0]                          err_flags
);

    localparam int               PIX_W   = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam logic [CNT_W-1:0] LINES_C = CNT_W'(PIPE_LINES);
    localparam logic [CNT_W-1:0] EXTRA_C = CNT_W'(PIPE_EXTRA);

    seq_state_e       state, state_nxt;
    logic [CNT_W-1:0] total, skip, in_cnt, fl_cnt;
    logic             dim_zero, in_last, out_done, out_active;

    assign dim_zero   = (width_in == '0) | (height_in == '0);
    assign in_last    = in_cnt == total - CNT_W'(1);
    assign busy       = state != IDLE;
    assign out_active = (state == STREAM) | (state == PAD) | (state == FLUSH) | (state == DRAIN);

    always_comb begin
        state_nxt  = state;
        src_read   = 1'b0;
        pipe_wr_en = 1'b0;
        pipe_din   = '0;
        ctrl_send  = 1'b0;
        case (state)
            IDLE: begin
                src_read = 1'b1;
                if (vip_ctrl_valid && !dim_zero) state_nxt = CTRL;
            end
            CTRL: begin
                if (!ctrl_busy) begin
                    ctrl_send = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                src_read = ~pipe_full;
                if (src_valid && !pipe_full) begin
                    pipe_wr_en = 1'b1;
                    pipe_din   = src_data;
                    if (in_last)      state_nxt = FLUSH;
                    else if (src_eov) state_nxt = PAD;
                end
            end
            PAD: begin
                if (!pipe_full) begin
                    pipe_wr_en = 1'b1;
                    if (in_last) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (fl_cnt >= skip) begin
                    state_nxt = DRAIN;
                end else if (!pipe_full) begin
                    pipe_wr_en = 1'b1;
                    if (fl_cnt == skip - CNT_W'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters are held at zero for the whole time the sequencer sits in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            total      <= '0;
            skip       <= '0;
            in_cnt     <= '0;
            fl_cnt     <= '0;
            width_out  <= DEF_WIDTH;
            height_out <= DEF_HEIGHT;
            err_flags  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                in_cnt <= '0;
                fl_cnt <= '0;
                if (vip_ctrl_valid) begin
                    width_out  <= width_in;
                    height_out <= height_in;
                    total      <= CNT_W'(width_in) * CNT_W'(height_in);
                    skip       <= LINES_C * CNT_W'(width_in) + EXTRA_C;
                    if (dim_zero) err_flags[ERR_ZERO_DIM] <= 1'b1;
                end
            end else begin
                if (pipe_wr_en && state != FLUSH) in_cnt <= in_cnt + CNT_W'(1);
                if (pipe_wr_en && state == FLUSH) fl_cnt <= fl_cnt + CNT_W'(1);
                if (state == STREAM && pipe_wr_en) begin
                    if (in_last && !src_eov)      err_flags[ERR_MISSING_EOV] <= 1'b1;
                    else if (!in_last && src_eov) err_flags[ERR_EARLY_EOV]   <= 1'b1;
                end
            end
        end
    end

    canny_seq_out_stage #(
        .PIX_W(BITS_PER_SYMBOL)
    ) u_out_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (out_active),
        .clear     (state == IDLE),
        .total     (total),
        .skip      (skip),
        .pipe_empty(pipe_empty),
        .pipe_dout (pipe_dout),
        .pipe_rd_en(pipe_rd_en),
        .out_stall (out_stall),
        .out_write (out_write),
        .out_data  (out_data),
        .out_eov   (out_eov),
        .done      (out_done)
    );

endmodule

// File: tb/tb_canny_frame_sequencer.sv
// Bench for canny_frame_sequencer: delay-line pipeline stand-in, randomized
// source/sink timing, and a frame-level reference of the expected outputs.
module tb_canny_frame_sequencer;

    localparam int W_T     = 4;
    localparam int H_T     = 2;
    localparam int SKIP_TB = 1 * W_T + 1;
    localparam int BUDGET  = 2000;

    logic        clk, rst_n;
    logic        vip_ctrl_valid, ctrl_busy, ctrl_send;
    logic [15:0] width_in, height_in, width_out, height_out;
    logic        src_valid, src_eov, src_read;
    logic [23:0] src_data, pipe_din;
    logic        pipe_wr_en, pipe_full, pipe_empty, pipe_rd_en;
    logic [7:0]  pipe_dout, out_data;
    logic        out_write, out_eov, out_stall, busy;
    logic [2:0]  err_flags;

    canny_frame_sequencer #(
        .BITS_PER_SYMBOL (8),
        .SYMBOLS_PER_BEAT(3),
        .PIPE_LINES      (1),
        .PIPE_EXTRA      (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .vip_ctrl_valid(vip_ctrl_valid),
        .width_in      (width_in),
        .height_in     (height_in),
        .ctrl_busy     (ctrl_busy),
        .ctrl_send     (ctrl_send),
        .width_out     (width_out),
        .height_out    (height_out),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .src_eov       (src_eov),
        .src_read      (src_read),
        .pipe_wr_en    (pipe_wr_en),
        .pipe_din      (pipe_din),
        .pipe_full     (pipe_full),
        .pipe_empty    (pipe_empty),
        .pipe_rd_en    (pipe_rd_en),
        .pipe_dout     (pipe_dout),
        .out_write     (out_write),
        .out_data      (out_data),
        .out_eov       (out_eov),
        .out_stall     (out_stall),
        .busy          (busy),
        .err_flags     (err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pipeline stand-in: each write yields one output, delayed by SKIP_TB writes.
    logic [7:0] dl[$];
    logic [7:0] ofifo[$];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl.delete();
            ofifo.delete();
            pipe_empty <= 1'b1;
            pipe_dout  <= 8'h00;
        end else begin
            if (pipe_rd_en && ofifo.size() > 0) void'(ofifo.pop_front());
            if (pipe_wr_en) begin
                dl.push_back(pipe_din[7:0]);
                if (dl.size() > SKIP_TB) ofifo.push_back(dl.pop_front());
                else ofifo.push_back(8'h00);
            end
            pipe_empty <= (ofifo.size() == 0);
            pipe_dout  <= (ofifo.size() > 0) ? ofifo[0] : 8'h00;
        end
    end

    // Observer: records output transfers and protocol facts at the falling edge.
    logic [8:0] got_q[$];
    int         wr_cnt = 0, ctrl_cnt = 0, hold_bad = 0, full_bad = 0;
    logic       hold_v = 1'b0;
    logic [8:0] hold_val = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && (out_write !== 1'b1 || {out_eov, out_data} !== hold_val)) hold_bad++;
            hold_v   = out_write & out_stall;
            hold_val = {out_eov, out_data};
            if (out_write && !out_stall) got_q.push_back({out_eov, out_data});
            if (pipe_wr_en) begin
                wr_cnt++;
                if (pipe_full) full_bad++;
            end
            if (ctrl_send) ctrl_cnt++;
        end
    end

    logic [2:0] exp_err = 3'b000;

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_frame(input int n_pix, input int eov_idx, input int stall_pct,
                             input int full_pct, input int st0, input int abort_at);
        logic [23:0] pix[16];
        logic [8:0]  exp_q[$];
        int total, frame_len, idx, cyc, got_base, wr_base, ctrl_base;
        bit done, timed_out;
        total = W_T * H_T;
        for (int k = 0; k < 16; k++) pix[k] = 24'($urandom);
        frame_len = (eov_idx >= 0 && eov_idx < total - 1) ? eov_idx + 1 : total;
        for (int k = 0; k < total; k++)
            exp_q.push_back({(k == total - 1), (k < frame_len) ? pix[k][7:0] : 8'h00});
        got_base  = got_q.size();
        wr_base   = wr_cnt;
        ctrl_base = ctrl_cnt;

        width_in       = 16'(W_T);
        height_in      = 16'(H_T);
        vip_ctrl_valid = 1'b1;
        @(posedge clk); #1;
        vip_ctrl_valid = 1'b0;
        idx = 0; cyc = 0; done = 0; timed_out = 0;
        while (!done) begin
            ctrl_busy = (cyc < 2);
            src_valid = (idx < n_pix) && ($urandom_range(99) < 75);
            src_data  = src_valid ? pix[idx] : 24'($urandom);
            src_eov   = src_valid && (idx == eov_idx);
            out_stall = (cyc >= st0 && cyc < st0 + 3) || ($urandom_range(99) < stall_pct);
            pipe_full = ($urandom_range(99) < full_pct);
            @(negedge clk);
            if (src_valid && src_read) idx++;
            cyc++;
            if (idx >= n_pix && !busy) done = 1;
            if (abort_at >= 0 && idx >= abort_at) done = 1;
            if (cyc >= BUDGET) begin done = 1; timed_out = 1; end
            @(posedge clk); #1;
        end
        src_valid = 1'b0; src_eov = 1'b0; out_stall = 1'b0; pipe_full = 1'b0; ctrl_busy = 1'b0;
        check("frame_timeout", 32'(timed_out), 0);
        if (abort_at >= 0) return;

        if (eov_idx >= 0 && eov_idx < total - 1) exp_err[1] = 1'b1;
        else if (eov_idx != total - 1)           exp_err[2] = 1'b1;
        check("out_count", got_q.size() - got_base, total);
        for (int k = 0; k < total; k++)
            if (got_base + k < got_q.size())
                check($sformatf("out_pix%0d", k), 32'(got_q[got_base + k]), 32'(exp_q[k]));
        check("pipe_writes", wr_cnt - wr_base, total + SKIP_TB);
        check("ctrl_pulses", ctrl_cnt - ctrl_base, 1);
        check("err_flags", 32'(err_flags), 32'(exp_err));
        check("width_out", 32'(width_out), W_T);
        check("height_out", 32'(height_out), H_T);
        check("busy_after", 32'(busy), 0);
        check("stall_hold", hold_bad, 0);
        check("write_when_full", full_bad, 0);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_busy"}, 32'(busy), 0);
        check({pfx, "_out_write"}, 32'(out_write), 0);
        check({pfx, "_out_data"}, 32'(out_data), 0);
        check({pfx, "_out_eov"}, 32'(out_eov), 0);
        check({pfx, "_ctrl_send"}, 32'(ctrl_send), 0);
        check({pfx, "_width"}, 32'(width_out), 640);
        check({pfx, "_height"}, 32'(height_out), 480);
        check({pfx, "_err"}, 32'(err_flags), 0);
        check({pfx, "_src_read"}, 32'(src_read), 1);
    endtask

    initial begin
        int ctrl_base;
        rst_n = 1'b0; vip_ctrl_valid = 1'b0; ctrl_busy = 1'b0;
        width_in = '0; height_in = '0; src_valid = 1'b0; src_data = '0; src_eov = 1'b0;
        pipe_full = 1'b0; out_stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Normal frame, then heavy back-pressure with a forced 3-cycle stall
        run_frame(8, 7, 0, 0, -100, -1);
        run_frame(8, 7, 30, 30, 15, -1);
        // Early eov on pixel 5, then no eov at all plus a stray 9th pixel
        run_frame(5, 4, 20, 20, -100, -1);
        run_frame(9, -1, 20, 20, -100, -1);

        // Zero width control packet
        ctrl_base      = ctrl_cnt;
        width_in       = 16'd0;
        height_in      = 16'd480;
        vip_ctrl_valid = 1'b1;
        @(posedge clk); #1;
        vip_ctrl_valid = 1'b0;
        exp_err[0]     = 1'b1;
        @(negedge clk);
        check("zdim_busy", 32'(busy), 0);
        check("zdim_ctrl_send", 32'(ctrl_send), 0);
        check("zdim_err", 32'(err_flags), 32'(exp_err));
        check("zdim_width", 32'(width_out), 0);
        check("zdim_height", 32'(height_out), 480);
        @(posedge clk); #1;
        check("zdim_ctrl_pulses", ctrl_cnt - ctrl_base, 0);

        // Reset after three accepted pixels, then a clean frame
        run_frame(8, 7, 0, 0, -100, 3);
        check("abort_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        exp_err = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(8, 7, 20, 20, -100, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
